serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl.sv | 144 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one 1-bit full adder walks the operands
// LSB first over W cycles, then presents sum/cout/ovf with a one-cycle done pulse.

module yAdder1 (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic z_o,
  output logic cout_o
);

  assign z_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

module serial_adder_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     opa_q, opa_d;
  logic [W-1:0]     opb_q, opb_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_s;
  logic             fa_co;

  // The only adder in the datapath; operands are shifted so bit 0 is always current.
  yAdder1 u_fa (
    .a_i    (opa_q[0]),
    .b_i    (opb_q[0]),
    .cin_i  (carry_q),
    .z_o    (fa_s),
    .cout_o (fa_co)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1, so cin is replaced by the forced carry.
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          count_d = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        acc_d   = {fa_s, acc_q[W-1:1]};
        carry_d = fa_co;
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST) begin
          // carry_q here is the carry into the MSB; visible results change only now.
          sum_d   = {fa_s, acc_q[W-1:1]};
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          count_d = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    opa_q <= opa_d;
    opb_q <= opb_d;
    acc_q <= acc_d;
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: expected results are queued at issue
// and popped by an independent monitor on every done pulse.

module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  serial_adder_ctrl #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Plain integer arithmetic: unsigned result mod 2^W, signed range test for ovf.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic ci, input logic sb);
    int   ua, ub, r, sa, sbv, sr;
    exp_t e;
    ua  = int'(av);
    ub  = int'(bv);
    sa  = (ua >= 128) ? ua - 256 : ua;
    sbv = (ub >= 128) ? ub - 256 : ub;
    if (sb) begin
      r  = ua - ub + 256;
      sr = sa - sbv;
    end else begin
      r  = ua + ub + int'(ci);
      sr = sa + sbv + int'(ci);
    end
    e.s = r[7:0];
    e.c = r[8];
    e.o = (sr > 127) || (sr < -128);
    return e;
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done act=1 exp=0");
      end else begin
        mon_e = exp_q.pop_front();
        chk("sum", int'(sum), int'(mon_e.s));
        chk("cout", int'(cout), int'(mon_e.c));
        chk("ovf", int'(ovf), int'(mon_e.o));
      end
    end
  end

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (done !== 1'b1 && cyc < 3 * W);
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout act=%0d exp=%0d", cyc, W + 1);
    end
  endtask

  // Issues one operation and scrambles the inputs while it runs.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ci, input logic sb);
    int cyc;
    @(negedge clk);
    a = av; b = bv; cin = ci; sub = sb; start = 1'b1;
    exp_q.push_back(model(av, bv, ci, sb));
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        chk("busy_run", int'(busy), 1);
        a = 8'($urandom); b = 8'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
      end
    end while (done !== 1'b1 && cyc < 3 * W);
    chk("latency_edges", cyc, W + 1);
    @(negedge clk);
    chk("done_pulse_end", int'(done), 0);
    chk("busy_idle", int'(busy), 0);
  endtask

  initial begin
    int cyc;
    int base;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sum", int'(sum), 0);
    chk("rst_cout", int'(cout), 0);
    chk("rst_ovf", int'(ovf), 0);

    start = 1'b1;
    @(negedge clk);
    chk("start_in_reset", int'(busy), 0);
    rst_n = 1'b1; start = 1'b0;

    do_op(8'hFF, 8'h01, 1'b0, 1'b0);
    do_op(8'h7F, 8'h01, 1'b1, 1'b0);
    do_op(8'h05, 8'h07, 1'b1, 1'b1);
    do_op(8'h80, 8'h01, 1'b0, 1'b1);
    do_op(8'h00, 8'h00, 1'b0, 1'b1);
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    do_op(8'h00, 8'h01, 1'b0, 1'b1);

    // Input changes and a start pulse during RUN must not disturb the result.
    @(negedge clk);
    base = done_cnt;
    a = 8'h10; b = 8'h20; cin = 1'b0; sub = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h10, 8'h20, 1'b0, 1'b0));
    @(negedge clk);
    start = 1'b0; a = 8'hAA; b = 8'h55; cin = 1'b1; sub = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    @(negedge clk);
    chk("single_done", done_cnt - base, 1);

    // Held start: second operation accepted on the first IDLE edge after DONE.
    @(negedge clk);
    a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h11, 8'h22, 1'b0, 1'b0));
    wait_done(cyc);
    a = 8'h40; b = 8'h02;
    exp_q.push_back(model(8'h40, 8'h02, 1'b0, 1'b0));
    @(negedge clk);
    chk("b2b_idle_gap", int'(busy), 0);
    @(negedge clk);
    chk("b2b_accept", int'(busy), 1);
    start = 1'b0;
    wait_done(cyc);
    chk("b2b_spacing", cyc + 2, W + 2);
    @(negedge clk);

    // Reset sampled on the 4th RUN edge abandons the operation.
    @(negedge clk);
    base = done_cnt;
    a = 8'h33; b = 8'h44; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_sum", int'(sum), 0);
    chk("midrst_cout", int'(cout), 0);
    chk("midrst_ovf", int'(ovf), 0);
    rst_n = 1'b1;
    repeat (W + 3) @(negedge clk);
    chk("midrst_no_done", done_cnt - base, 0);
    do_op(8'h03, 8'h04, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
